// File: rtl/mvm_requant_if.sv
// rtl/mvm_requant_if.sv - result-beat input and packed-word output bundle for mvm_requant
//
// Purpose: groups the MVM result beat, the requantized output stream, and the
// overflow flag/clear into one interface.
// Ports (signals):
//   i_result[NUM_OLANES] signed OWIDTH : result lanes from the MVM
//   i_valid, i_shift[4:0]              : beat valid and right-shift amount
//   o_data[NUM_OLANES*QWIDTH]          : packed output word, lane k at [k*QWIDTH +: QWIDTH]
//   o_valid / i_ready                  : output handshake (FIFO head valid / consumer ready)
//   o_count                            : FIFO occupancy
//   o_overflow / i_clr_overflow        : sticky drop flag and its clear
// Modports: master = producer/consumer side, slave = mvm_requant side.
interface mvm_requant_if #(
    parameter int OWIDTH     = 32,
    parameter int NUM_OLANES = 8,
    parameter int QWIDTH     = 8,
    parameter int FIFO_DEPTH = 16
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic signed [OWIDTH-1:0]       i_result [0:NUM_OLANES-1];
    logic                           i_valid;
    logic [4:0]                     i_shift;
    logic [NUM_OLANES*QWIDTH-1:0]   o_data;
    logic                           o_valid;
    logic                           i_ready;
    logic [CW-1:0]                  o_count;
    logic                           o_overflow;
    logic                           i_clr_overflow;

    modport master (
        output i_result, i_valid, i_shift, i_ready, i_clr_overflow,
        input  o_data, o_valid, o_count, o_overflow
    );

    modport slave (
        input  i_result, i_valid, i_shift, i_ready, i_clr_overflow,
        output o_data, o_valid, o_count, o_overflow
    );
endinterface

// File: rtl/mvm_requant.sv
// rtl/mvm_requant.sv - two-stage round/shift/saturate requantizer with FWFT output FIFO
//
// Purpose: per lane, adds a round-half-up constant, arithmetic-shifts right,
// saturates to QWIDTH signed, packs the lanes into one word and buffers it in
// a first-word-fall-through FIFO. Words arriving while the FIFO is full (and
// not being popped) are dropped and flagged in a sticky overflow bit.
// Ports:
//   clk  : single clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : mvm_requant_if.slave (result beat in, packed word stream out, status)
module mvm_requant #(
    parameter int OWIDTH     = 32,
    parameter int NUM_OLANES = 8,
    parameter int QWIDTH     = 8,
    parameter int FIFO_DEPTH = 16
) (
    input logic           clk,
    input logic           rst,
    mvm_requant_if.slave  bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = OWIDTH + 1;
    localparam int DW = NUM_OLANES * QWIDTH;
    localparam logic signed [SW-1:0] QMAX = SW'((2 ** (QWIDTH - 1)) - 1);
    localparam logic signed [SW-1:0] QMIN = SW'(-(2 ** (QWIDTH - 1)));

    // Stage 1: biased sums. One extra bit so the +2^(shift-1) bias never wraps.
    logic                  s1_valid;
    logic [4:0]            s1_shift;
    logic signed [SW-1:0]  s1_sum [NUM_OLANES];
    logic signed [SW-1:0]  rnd;

    // Stage 2: packed saturated word.
    logic                  s2_valid;
    logic [DW-1:0]         s2_data;
    logic [DW-1:0]         q_word;
    logic signed [SW-1:0]  shifted;

    // FIFO
    logic [DW-1:0]         mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    logic                  overflow;
    logic                  full;
    logic                  pop;
    logic                  push;
    logic                  drop;

    always_comb begin
        rnd = '0;
        if (bus.i_shift != 5'd0) begin
            rnd = SW'(1) << (bus.i_shift - 5'd1);
        end
    end

    always_comb begin
        q_word  = '0;
        shifted = '0;
        for (int k = 0; k < NUM_OLANES; k++) begin
            shifted = s1_sum[k] >>> s1_shift;
            if (shifted > QMAX) begin
                q_word[k*QWIDTH +: QWIDTH] = QMAX[QWIDTH-1:0];
            end else if (shifted < QMIN) begin
                q_word[k*QWIDTH +: QWIDTH] = QMIN[QWIDTH-1:0];
            end else begin
                q_word[k*QWIDTH +: QWIDTH] = shifted[QWIDTH-1:0];
            end
        end
    end

    // Datapath registers carry no reset; only the valids qualify them.
    always_ff @(posedge clk) begin
        if (bus.i_valid) begin
            for (int k = 0; k < NUM_OLANES; k++) begin
                s1_sum[k] <= $signed({bus.i_result[k][OWIDTH-1], bus.i_result[k]}) + rnd;
            end
            s1_shift <= bus.i_shift;
        end
        if (s1_valid) begin
            s2_data <= q_word;
        end
        if (push) begin
            mem[wr_ptr] <= s2_data;
        end
    end

    assign full = (count == CW'(FIFO_DEPTH));
    assign pop  = (count != '0) && bus.i_ready;
    // A pop frees the slot on the same edge, so a full FIFO still takes a push.
    assign push = s2_valid && (!full || pop);
    assign drop = s2_valid && full && !pop;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            s1_valid <= bus.i_valid;
            s2_valid <= s1_valid;
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
            if (drop) begin
                overflow <= 1'b1;
            end else if (bus.i_clr_overflow) begin
                overflow <= 1'b0;
            end
        end
    end

    assign bus.o_data     = mem[rd_ptr];
    assign bus.o_valid    = (count != '0);
    assign bus.o_count    = count;
    assign bus.o_overflow = overflow;
endmodule
